io_bus_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares the single processor-side IO register port (Sys_WrData / Sys_Address / Sys_WrEn / Sys_RdEn / Sys_RdData) between NUM_MASTERS requesters, e.g. the CPU data port and a debug/DMA master.
- Issues exactly one register access at a time and waits out the fixed read latency of the IO block.
- Returns read data and a completion pulse to the owning master.
- Sits between the masters and the IO subsystem, in the Sys_Clock domain.

---
 rtl/io_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 34 +++
 rtl/io_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types for the IO register-port arbiter: FSM state encoding and
// the read-latency counter width helper.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    // Counter must hold the value RD_LATENCY itself.
    function automatic int unsigned lat_cnt_w(input int unsigned rd_latency);
        return $clog2(rd_latency + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer, scanning upward with wrap.
module rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    int unsigned w_j;

    always_comb begin
        o_gnt_c   = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = 32'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!o_valid_c && i_req[IDX_W'(w_j)]) begin
                o_valid_c              = 1'b1;
                o_gnt_c[IDX_W'(w_j)]   = 1'b1;
                o_idx_c                = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and single-outstanding access sequencer sharing the
// processor-side IO register port between NUM_MASTERS requesters.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                               Sys_Clock,
    input  logic                               Sys_Reset,
    input  logic [NUM_MASTERS-1:0]             M_Req,
    input  logic [NUM_MASTERS-1:0]             M_Write,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] M_Address,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0] M_WrData,
    output logic [NUM_MASTERS-1:0]             M_Gnt,
    output logic [NUM_MASTERS-1:0]             M_Done,
    output logic [DATA_W-1:0]                  M_RdData,
    output logic [ADDR_W-1:0]                  Sys_Address,
    output logic [DATA_W-1:0]                  Sys_WrData,
    output logic                               Sys_WrEn,
    output logic                               Sys_RdEn,
    input  logic [DATA_W-1:0]                  Sys_RdData
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CNT_W = lat_cnt_w(RD_LATENCY);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic [NUM_MASTERS-1:0] r_gnt,     w_gnt_nxt;
    logic [NUM_MASTERS-1:0] r_done,    w_done_nxt;
    logic [DATA_W-1:0]      r_rddata,  w_rddata_nxt;
    logic [ADDR_W-1:0]      r_addr,    w_addr_nxt;
    logic [DATA_W-1:0]      r_wrdata,  w_wrdata_nxt;
    logic                   r_wren,    w_wren_nxt;
    logic                   r_rden,    w_rden_nxt;
    logic                   r_write,   w_write_nxt;
    logic [IDX_W-1:0]       r_idx,     w_idx_nxt;
    logic [IDX_W-1:0]       r_ptr,     w_ptr_nxt;
    logic [CNT_W-1:0]       r_cnt,     w_cnt_nxt;

    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_rd_last;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req     (M_Req),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_pick_gnt),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    assign w_rd_last = (r_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge Sys_Clock) begin
        if (!Sys_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = r_write ? DONE : WAIT_RD;
            WAIT_RD: if (w_rd_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; the bus outputs double as the
    // latched transaction so they hold their last values while idle.
    always_comb begin
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_rddata_nxt = r_rddata;
        w_addr_nxt   = r_addr;
        w_wrdata_nxt = r_wrdata;
        w_wren_nxt   = 1'b0;
        w_rden_nxt   = 1'b0;
        w_write_nxt  = r_write;
        w_idx_nxt    = r_idx;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_valid) begin
                    w_gnt_nxt    = w_pick_gnt;
                    w_idx_nxt    = w_pick_idx;
                    w_write_nxt  = M_Write[w_pick_idx];
                    w_addr_nxt   = M_Address[w_pick_idx];
                    w_wrdata_nxt = M_WrData[w_pick_idx];
                    w_wren_nxt   = M_Write[w_pick_idx];
                    w_rden_nxt   = !M_Write[w_pick_idx];
                end
            end
            ISSUE: begin
                if (r_write) begin
                    w_done_nxt = r_gnt;
                end else begin
                    w_cnt_nxt = CNT_W'(RD_LATENCY);
                end
            end
            WAIT_RD: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (w_rd_last) begin
                    w_rddata_nxt = Sys_RdData;
                    w_done_nxt   = r_gnt;
                end
            end
            DONE: begin
                w_gnt_nxt = '0;
                if (r_idx == IDX_W'(NUM_MASTERS - 1)) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_gnt_nxt = '0;
            end
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge Sys_Clock) begin
        if (!Sys_Reset) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_rddata <= '0;
            r_addr   <= '0;
            r_wrdata <= '0;
            r_wren   <= 1'b0;
            r_rden   <= 1'b0;
            r_write  <= 1'b0;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_rddata <= w_rddata_nxt;
            r_addr   <= w_addr_nxt;
            r_wrdata <= w_wrdata_nxt;
            r_wren   <= w_wren_nxt;
            r_rden   <= w_rden_nxt;
            r_write  <= w_write_nxt;
            r_idx    <= w_idx_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign M_Gnt       = r_gnt;
    assign M_Done      = r_done;
    assign M_RdData    = r_rddata;
    assign Sys_Address = r_addr;
    assign Sys_WrData  = r_wrdata;
    assign Sys_WrEn    = r_wren;
    assign Sys_RdEn    = r_rden;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed + randomized bench for io_bus_arbiter against a transaction-level
// round-robin model and a fixed-latency slave.
module tb_io_bus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned L  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [N-1:0]         wr;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wdata;
    logic [N-1:0]         gnt;
    logic [N-1:0]         done;
    logic [DW-1:0]        m_rd;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wd;
    logic                 s_wren;
    logic                 s_rden;
    logic [DW-1:0]        s_rd;

    logic [L-1:0]         pv;
    logic [L-1:0][DW-1:0] pd;
    logic [DW-1:0]        garbage;

    int checks   = 0;
    int failures = 0;
    int ptr;
    logic [DW-1:0] last_rd;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wd;

    always #5 clk = ~clk;

    io_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RD_LATENCY  (L)
    ) dut (
        .Sys_Clock   (clk),
        .Sys_Reset   (rst_n),
        .M_Req       (req),
        .M_Write     (wr),
        .M_Address   (addr),
        .M_WrData    (wdata),
        .M_Gnt       (gnt),
        .M_Done      (done),
        .M_RdData    (m_rd),
        .Sys_Address (s_addr),
        .Sys_WrData  (s_wd),
        .Sys_WrEn    (s_wren),
        .Sys_RdEn    (s_rden),
        .Sys_RdData  (s_rd)
    );

    function automatic logic [DW-1:0] slave_val(input logic [AW-1:0] a);
        if (a == 30'h4) return 32'h1234_5678;
        return {a, 2'b01} ^ 32'hA5C3_0F96;
    endfunction

    // Slave: data is valid exactly L cycles after the RdEn cycle, noise otherwise.
    always @(posedge clk) begin
        pv      <= {pv[L-2:0], s_rden};
        pd      <= {pd[L-2:0], slave_val(s_addr)};
        garbage <= $urandom;
    end
    assign s_rd = pv[L-1] ? pd[L-1] : garbage;

    always @(negedge clk) begin
        checks++;
        assert (!(s_wren && s_rden) && $onehot0(gnt) && $onehot0(done))
        else begin
            failures++;
            $error("FAIL excl wren=%0b rden=%0b gnt=%0b done=%0b", s_wren, s_rden, gnt, done);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"},  64'(gnt),    64'(0));
        chk({tag, ".done"}, 64'(done),   64'(0));
        chk({tag, ".en"},   64'({s_wren, s_rden}), 64'(0));
        chk({tag, ".rd"},   64'(m_rd),   64'(last_rd));
        chk({tag, ".addr"}, 64'(s_addr), 64'(last_addr));
        chk({tag, ".wd"},   64'(s_wd),   64'(last_wd));
    endtask

    // Called in an IDLE cycle with the request pattern r; returns at the Done cycle.
    task automatic run_txn(input logic [N-1:0] r, input bit drop_mid);
        int w;
        logic [N-1:0] oh;
        logic is_wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        w = -1;
        for (int k = 0; k < int'(N); k++) begin
            if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
        end
        oh    = N'(1) << w;
        is_wr = wr[w];
        ea    = addr[w];
        ed    = wdata[w];
        chk_idle("t0");
        req = r;
        tick();
        chk("issue.gnt",  64'(gnt),    64'(oh));
        chk("issue.wren", 64'(s_wren), 64'(is_wr));
        chk("issue.rden", 64'(s_rden), 64'(!is_wr));
        chk("issue.addr", 64'(s_addr), 64'(ea));
        chk("issue.wd",   64'(s_wd),   64'(ed));
        chk("issue.done", 64'(done),   64'(0));
        if (drop_mid && is_wr) req[w] = 1'b0;
        tick();
        if (!is_wr) begin
            for (int i = 0; i < int'(L); i++) begin
                chk("wait.done", 64'(done), 64'(0));
                chk("wait.en",   64'({s_wren, s_rden}), 64'(0));
                chk("wait.gnt",  64'(gnt),  64'(oh));
                if (drop_mid && i == 0) req[w] = 1'b0;
                tick();
            end
            last_rd = slave_val(ea);
        end
        chk("done.done", 64'(done), 64'(oh));
        chk("done.gnt",  64'(gnt),  64'(oh));
        chk("done.en",   64'({s_wren, s_rden}), 64'(0));
        chk("done.rd",   64'(m_rd), 64'(last_rd));
        last_addr = ea;
        last_wd   = ed;
        ptr       = (w + 1) % N;
    endtask

    task automatic randomize_ops();
        for (int m = 0; m < int'(N); m++) begin
            wr[m]    = 1'($urandom);
            addr[m]  = AW'($urandom);
            wdata[m] = $urandom;
        end
    endtask

    initial begin
        pv        = '0;
        pd        = '0;
        garbage   = '0;
        ptr       = 0;
        last_rd   = '0;
        last_addr = '0;
        last_wd   = '0;
        rst_n     = 1'b0;
        req       = 2'b11;
        randomize_ops();

        // Reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("reset");
        end
        rst_n = 1'b1;
        req   = '0;
        tick();

        // Single write from M0
        wr[0] = 1'b1; addr[0] = 30'h10; wdata[0] = 32'hDEAD_BEEF;
        run_txn(2'b01, 1'b0);
        tick();

        // Read from M1 at 0x04
        wr[1] = 1'b0; addr[1] = 30'h4;
        run_txn(2'b10, 1'b0);
        tick();

        // Continuous contention alternates owners
        randomize_ops();
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 1'b0);
            tick();
        end

        // Req dropped mid-read still completes
        wr[0] = 1'b0; addr[0] = 30'h2A;
        run_txn(2'b01, 1'b1);
        tick();

        // Reset during WAIT_RD aborts; pointer returns to 0
        wr[1] = 1'b0; addr[1] = 30'h55;
        req = 2'b10;
        tick();
        chk("abort.issue", 64'(s_rden), 64'(1));
        tick();
        chk("abort.wait", 64'(s_rden), 64'(0));
        rst_n = 1'b0;
        tick();
        last_rd = '0; last_addr = '0; last_wd = '0; ptr = 0;
        chk_idle("abort.rst");
        rst_n = 1'b1;
        req   = '0;
        tick();
        chk_idle("abort.after");
        randomize_ops();
        run_txn(2'b11, 1'b0);
        tick();

        // Random traffic with idle gaps
        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] r;
            randomize_ops();
            r = N'($urandom_range(0, (1 << N) - 1));
            if (r == '0) begin
                req = '0;
                tick();
                chk_idle("gap");
            end else begin
                run_txn(r, 1'($urandom));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
